spi_slave_rx: RTL and testbench

- Receive-side SPI endpoint, running entirely on the system clock.
- Oversamples the sclk/cs/mosi lines driven by the team's SPI master and deserialises 12-bit LSB-first words.
- Presents each completed word on a valid/ready handshake and flags framing errors and overruns.
- Sits in the top-level alongside spi_master as the synthesizable, single-clock replacement for an sclk-clocked receiver.

---
 rtl/spi_slave_rx.sv | 187 ++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// spi_slave_rx
//   Receive-side SPI endpoint running entirely on clk. sclk/cs/mosi are
//   oversampled through synchronisers; mosi is captured on each detected
//   sclk falling edge (mid-bit, because the master drives mosi on rising edges).
//   Each completed DATA_W-bit word is offered on a valid/ready output.
//
//   Optional build macro: SPI_RX_MSB_FIRST_EN
//     undefined : LSB-first (first received bit lands in dout[0])
//     defined   : MSB-first (first received bit lands in dout[DATA_W-1])
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   sclk, cs      SPI clock / active-low chip select (asynchronous to clk)
//   mosi          SPI data (asynchronous to clk)
//   dout          received word, stable while dout_valid=1
//   dout_valid    word available; held until accepted
//   dout_ready    consumer accepts when dout_valid & dout_ready
//   busy          frame open (SHIFT, DONE or WAIT_CS)
//   frame_err     one-cycle pulse: cs rose after 1..DATA_W-1 bits
//   overrun       one-cycle pulse: a completed word was dropped
//   dbg_state     current FSM state (0 IDLE, 1 SHIFT, 2 DONE, 3 WAIT_CS)
//
// Handshake: a word transfers on every clk edge where dout_valid & dout_ready
// are both high. Once raised, dout_valid stays high and dout stays constant
// until that transfer happens. dout_ready has no effect while dout_valid=0.
module spi_slave_rx #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DONE    = 2'd2,
        WAIT_CS = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   armed_q, armed_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [DATA_W-1:0]      dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;

    logic sclk_s, cs_s, mosi_s, sclk_fall;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_fall = sclk_prev_q & ~sclk_s;

    // Synchroniser shift chains and edge-detect history.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_s;
        // fill_q tracks how far real samples have travelled down the chains
        // since reset; its top bit says cs_s no longer shows the reset value.
        fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        // A frame already open on the wire when reset released must not be
        // picked up half way: a genuine cs high must be seen first.
        armed_d      = armed_q | (cs_s & fill_q[SYNC_STAGES-1]);

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!cs_s && armed_q) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            SHIFT: begin
                if (cs_s) begin
                    if (cnt_q != '0) begin
                        frame_err_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sclk_fall) begin
`ifdef SPI_RX_MSB_FIRST_EN
                    shift_d = {shift_q[DATA_W-2:0], mosi_s};
`else
                    shift_d = {mosi_s, shift_q[DATA_W-1:1]};
`endif
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Load when the output slot is free or is being emptied now.
                if (!dout_valid_q || dout_ready) begin
                    dout_d       = shift_q;
                    dout_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
                state_d = WAIT_CS;
            end
            WAIT_CS: begin
                if (cs_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q  <= '0;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            fill_q       <= '0;
            sclk_prev_q  <= 1'b0;
            armed_q      <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            fill_q       <= fill_d;
            sclk_prev_q  <= sclk_prev_d;
            armed_q      <= armed_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q != IDLE);
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Testbench for spi_slave_rx: drives SPI frames from tasks, collects accepted
// words and flag pulses in a monitor, and checks against a word model that
// maps the wire bit order straight onto output bit positions.
module tb_spi_slave_rx;

    localparam int DATA_W      = 12;
    localparam int SYNC_STAGES = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sclk = 1'b0;
    logic              cs = 1'b1;
    logic              mosi = 1'b0;
    logic              dout_ready = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              busy;
    logic              frame_err;
    logic              overrun;
    logic [1:0]        dbg_state;

    spi_slave_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] got_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int last_fall_cyc = 0;
    int valid_rise_cyc = -1;
    logic prev_valid = 1'b0;
    logic prev_acc = 1'b0;
    logic [DATA_W-1:0] prev_dout = '0;

    // Monitor: records accepted words and flag pulses, and checks dout holds
    // steady while a word waits for acceptance.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
        end else begin
            if (prev_valid && !prev_acc && dout_valid) begin
                checks++;
                if (dout !== prev_dout) begin
                    errors++;
                    $display("FAIL dout_stable got %h exp %h", dout, prev_dout);
                end
            end
            if (dout_valid && !prev_valid) valid_rise_cyc = cyc;
            if (dout_valid && dout_ready) got_q.push_back(dout);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            prev_valid = dout_valid;
            prev_acc   = dout_valid && dout_ready;
            prev_dout  = dout;
        end
    end

    // ---------------- reference model ----------------
    // wire_bits[i] is the i-th bit on the wire.
    function automatic logic [DATA_W-1:0] model_word(input logic [31:0] wire_bits);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < DATA_W; i++) begin
`ifdef SPI_RX_MSB_FIRST_EN
            w[DATA_W-1-i] = wire_bits[i];
`else
            w[i] = wire_bits[i];
`endif
        end
        return w;
    endfunction

    function automatic logic [31:0] to_wire(input logic [DATA_W-1:0] word);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < DATA_W; i++) begin
`ifdef SPI_RX_MSB_FIRST_EN
            b[i] = word[DATA_W-1-i];
`else
            b[i] = word[i];
`endif
        end
        return b;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_send(input logic [31:0] bits, input int nbits,
                            input int half, input bit raise_cs);
        cs = 1'b0;
        wait_clks(half);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            mosi = bits[i];
            wait_clks(half);
            sclk = 1'b0;
            last_fall_cyc = cyc;
            wait_clks(half);
        end
        if (raise_cs) begin
            cs = 1'b1;
            wait_clks(half);
        end
    endtask

    task automatic clear_sb();
        got_q.delete();
        exp_q.delete();
        ferr_cnt = 0;
        ovr_cnt = 0;
        valid_rise_cyc = -1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        wait_clks(3);
        checks++;
        if (dout !== '0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_dout got %h/%b exp 000/0", dout, dout_valid);
        end
        checks++;
        if (busy !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b st=%0d exp 0/0", busy, dbg_state);
        end
        checks++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got %b%b exp 00", frame_err, overrun);
        end
        rst = 1'b0;
        wait_clks(8);
    endtask

    task automatic test_basic();
        int lat;
        clear_sb();
        dout_ready = 1'b1;
        spi_send(to_wire(12'hA5C), DATA_W, 11, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_open got %b exp 1", busy);
        end
        lat = valid_rise_cyc - last_fall_cyc;
        checks++;
        if (valid_rise_cyc < 0 || lat < 1 || lat > SYNC_STAGES + 3) begin
            errors++;
            $display("FAIL basic_latency got %0d exp 1..%0d", lat, SYNC_STAGES + 3);
        end
        cs = 1'b1;
        wait_clks(11);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_closed got %b exp 0", busy);
        end
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 12'hA5C) begin
            errors++;
            $display("FAIL basic_word got n=%0d w=%h exp n=1 w=a5c",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
        end
        checks++;
        if (ferr_cnt != 0 || ovr_cnt != 0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_flags got ferr=%0d ovr=%0d v=%b exp 0 0 0",
                     ferr_cnt, ovr_cnt, dout_valid);
        end
    endtask

    task automatic test_overrun();
        clear_sb();
        dout_ready = 1'b0;
        spi_send(to_wire(12'h123), DATA_W, 6, 1'b1);
        spi_send(to_wire(12'hFFF), DATA_W, 6, 1'b1);
        checks++;
        if (dout_valid !== 1'b1 || dout !== 12'h123) begin
            errors++;
            $display("FAIL ovr_held got v=%b d=%h exp 1 123", dout_valid, dout);
        end
        checks++;
        if (ovr_cnt != 1) begin
            errors++;
            $display("FAIL ovr_pulse got %0d exp 1", ovr_cnt);
        end
        dout_ready = 1'b1;
        wait_clks(1);
        dout_ready = 1'b0;
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear got %b exp 0", dout_valid);
        end
        wait_clks(10);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 12'h123 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_words got n=%0d w=%h exp n=1 w=123",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
        end
    endtask

    task automatic test_frame_err();
        clear_sb();
        dout_ready = 1'b1;
        spi_send(32'($urandom), 5, 6, 1'b1);
        wait_clks(4);
        checks++;
        if (ferr_cnt != 1) begin
            errors++;
            $display("FAIL ferr_pulse got %0d exp 1", ferr_cnt);
        end
        checks++;
        if (got_q.size() != 0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL ferr_noword got n=%0d v=%b exp 0 0", got_q.size(), dout_valid);
        end
        spi_send(to_wire(12'h00F), DATA_W, 6, 1'b1);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 12'h00F || ferr_cnt != 1) begin
            errors++;
            $display("FAIL ferr_next got n=%0d w=%h ferr=%0d exp 1 00f 1",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, ferr_cnt);
        end
    endtask

    task automatic test_extra_bits();
        logic [31:0] bits;
        clear_sb();
        dout_ready = 1'b1;
        bits = to_wire(12'h3C1);
        bits[DATA_W]   = 1'b1;
        bits[DATA_W+1] = 1'b1;
        spi_send(bits, DATA_W + 2, 5, 1'b1);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 12'h3C1) begin
            errors++;
            $display("FAIL extra_word got n=%0d w=%h exp 1 3c1",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
        end
        checks++;
        if (ferr_cnt != 0 || ovr_cnt != 0) begin
            errors++;
            $display("FAIL extra_flags got ferr=%0d ovr=%0d exp 0 0", ferr_cnt, ovr_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] bits;
        clear_sb();
        dout_ready = 1'b0;
        spi_send(to_wire(12'h5A5), DATA_W, 6, 1'b1);   // left pending
        bits = to_wire(12'h0AA);
        spi_send(bits, 6, 6, 1'b0);
        rst = 1'b1;
        wait_clks(1);
        checks++;
        if (dout_valid !== 1'b0 || dout !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear got v=%b d=%h b=%b exp 0 000 0",
                     dout_valid, dout, busy);
        end
        wait_clks(1);
        rst = 1'b0;
        dout_ready = 1'b1;
        spi_send(bits >> 6, 6, 6, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_busy got %b exp 0", busy);
        end
        cs = 1'b1;
        wait_clks(6);
        checks++;
        if (got_q.size() != 0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_noword got n=%0d v=%b exp 0 0", got_q.size(), dout_valid);
        end
        spi_send(to_wire(12'h7E0), DATA_W, 6, 1'b1);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 12'h7E0) begin
            errors++;
            $display("FAIL rstmid_next got n=%0d w=%h exp 1 7e0",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
        end
    endtask

`ifdef SPI_RX_MSB_FIRST_EN
    task automatic test_msb_first();
        logic [11:0] seq;
        logic [31:0] bits;
        clear_sb();
        dout_ready = 1'b1;
        seq = 12'b0011_1010_0101;   // read right to left: 1,0,1,0,0,1,0,1,1,1,0,0
        bits = {20'd0, seq};
        spi_send(bits, DATA_W, 6, 1'b1);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 12'hA5C) begin
            errors++;
            $display("FAIL msb_word got n=%0d w=%h exp 1 a5c",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] bits;
        int extra;
        int half;
        clear_sb();
        dout_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            bits  = $urandom;
            extra = $urandom_range(0, 2);
            half  = $urandom_range(SYNC_STAGES + 2, 12);
            exp_q.push_back(model_word(bits));
            spi_send(bits, DATA_W + extra, half, 1'b1);
            wait_clks($urandom_range(0, 5));
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_word[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (ferr_cnt != 0 || ovr_cnt != 0) begin
            errors++;
            $display("FAIL rand_flags got ferr=%0d ovr=%0d exp 0 0", ferr_cnt, ovr_cnt);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_frame_err();
        test_extra_bits();
        test_reset_midframe();
`ifdef SPI_RX_MSB_FIRST_EN
        test_msb_first();
`endif
        test_random();
        wait_clks(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
